// File: rtl/timer_irq_unit.sv
// Machine-mode timer interrupt controller: owns mstatus/mie/mip/mtvec/mepc/mcause
// and an interrupt counter, requests traps from the pipeline and handles entry/mret.
module timer_irq_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_Tirq_timer_pending,
    input  logic        i_Tirq_csr_wen,
    input  logic [11:0] i_Tirq_csr_waddr,
    input  logic [63:0] i_Tirq_csr_wdata,
    input  logic [11:0] i_Tirq_csr_raddr,
    output logic [63:0] o_Tirq_csr_rdata,
    input  logic [63:0] i_Tirq_pc,
    input  logic        i_Tirq_ack,
    input  logic        i_Tirq_mret,
    output logic        o_Tirq_req,
    output logic [63:0] o_Tirq_target,
    output logic [63:0] o_Tirq_mepc
);
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;
    localparam logic [11:0] ADDR_IRQCNT  = 12'h7C0;
    localparam logic [63:0] CAUSE_MTI    = 64'h8000_0000_0000_0007;

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state;
    logic        req_q;
    logic        mtip_q;
    logic        st_mie;
    logic        st_mpie;
    logic        mtie;
    logic [63:0] mtvec;
    logic [63:0] mepc;
    logic [63:0] mcause;
    logic [31:0] irq_cnt;

    logic        fire;
    logic        trap;
    logic [63:0] tvec_base;
    logic [63:0] mstatus_rd;

    assign fire       = mtip_q & st_mie & mtie;
    assign trap       = (state == REQ) && i_Tirq_ack;
    assign tvec_base  = {mtvec[63:2], 2'b00};
    assign mstatus_rd = {51'd0, 2'b11, 3'd0, st_mpie, 3'd0, st_mie, 3'd0};

    assign o_Tirq_req    = req_q;
    assign o_Tirq_mepc   = mepc;
    assign o_Tirq_target = (mtvec[1:0] == 2'b01) ? tvec_base + 64'd28 : tvec_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            req_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (fire) begin
                    state <= REQ;
                    req_q <= 1'b1;
                end
                REQ: if (i_Tirq_ack || !fire) begin
                    // Ack is honoured even on the cycle the request is being withdrawn.
                    state <= IDLE;
                    req_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtip_q  <= 1'b0;
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
            mtie    <= 1'b0;
            mtvec   <= 64'd0;
            mepc    <= 64'd0;
            mcause  <= 64'd0;
            irq_cnt <= 32'd0;
        end else begin
            mtip_q <= i_Tirq_timer_pending;

            // Priority on mstatus: trap entry, then mret, then software write.
            if (trap) begin
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
            end else if (i_Tirq_mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (i_Tirq_csr_wen && i_Tirq_csr_waddr == ADDR_MSTATUS) begin
                st_mie  <= i_Tirq_csr_wdata[3];
                st_mpie <= i_Tirq_csr_wdata[7];
            end

            if (i_Tirq_csr_wen && i_Tirq_csr_waddr == ADDR_MIE)
                mtie <= i_Tirq_csr_wdata[7];
            if (i_Tirq_csr_wen && i_Tirq_csr_waddr == ADDR_MTVEC)
                mtvec <= i_Tirq_csr_wdata;

            if (trap)
                mepc <= i_Tirq_pc & ~64'h3;
            else if (i_Tirq_csr_wen && i_Tirq_csr_waddr == ADDR_MEPC)
                mepc <= i_Tirq_csr_wdata & ~64'h3;

            if (trap)
                mcause <= CAUSE_MTI;
            else if (i_Tirq_csr_wen && i_Tirq_csr_waddr == ADDR_MCAUSE)
                mcause <= i_Tirq_csr_wdata;

            if (trap && irq_cnt != 32'hFFFF_FFFF)
                irq_cnt <= irq_cnt + 32'd1;
        end
    end

    always_comb begin
        o_Tirq_csr_rdata = 64'd0;
        case (i_Tirq_csr_raddr)
            ADDR_MSTATUS: o_Tirq_csr_rdata = mstatus_rd;
            ADDR_MIE:     o_Tirq_csr_rdata = {56'd0, mtie, 7'd0};
            ADDR_MTVEC:   o_Tirq_csr_rdata = mtvec;
            ADDR_MEPC:    o_Tirq_csr_rdata = mepc;
            ADDR_MCAUSE:  o_Tirq_csr_rdata = mcause;
            ADDR_MIP:     o_Tirq_csr_rdata = {56'd0, mtip_q, 7'd0};
            ADDR_IRQCNT:  o_Tirq_csr_rdata = {32'd0, irq_cnt};
            default:      o_Tirq_csr_rdata = 64'd0;
        endcase
    end
endmodule
